// File: rtl/tlk2711_axil_reg_bridge.sv
// AXI4-Lite slave to tlk2711_top strobe registers: write strobe 2 cycles after the later AW/W beat, read data 2+RD_LATENCY cycles after AR.
// Back-pressure: one-entry AW/W holders; one transaction outstanding, B/R responses held until accepted.
module tlk2711_axil_reg_bridge #(
   parameter int REG_ADDR_WIDTH = 16,
   parameter int DATA_WIDTH     = 64,
   parameter int RD_LATENCY     = 1
) (
   input  logic                      clk,
   input  logic                      arst_n,
   input  logic [31:0]               s_axil_awaddr,
   input  logic                      s_axil_awvalid,
   output logic                      s_axil_awready,
   input  logic [DATA_WIDTH-1:0]     s_axil_wdata,
   input  logic [DATA_WIDTH/8-1:0]   s_axil_wstrb,
   input  logic                      s_axil_wvalid,
   output logic                      s_axil_wready,
   output logic [1:0]                s_axil_bresp,
   output logic                      s_axil_bvalid,
   input  logic                      s_axil_bready,
   input  logic [31:0]               s_axil_araddr,
   input  logic                      s_axil_arvalid,
   output logic                      s_axil_arready,
   output logic [DATA_WIDTH-1:0]     s_axil_rdata,
   output logic [1:0]                s_axil_rresp,
   output logic                      s_axil_rvalid,
   input  logic                      s_axil_rready,
   output logic                      o_reg_wen,
   output logic [REG_ADDR_WIDTH-1:0] o_reg_waddr,
   output logic [DATA_WIDTH-1:0]     o_reg_wdata,
   output logic                      o_reg_ren,
   output logic [REG_ADDR_WIDTH-1:0] o_reg_raddr,
   input  logic [DATA_WIDTH-1:0]     i_reg_rdata
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WR_EXEC = 3'd1;
   localparam logic [2:0] WR_RESP = 3'd2;
   localparam logic [2:0] RD_EXEC = 3'd3;
   localparam logic [2:0] RD_WAIT = 3'd4;
   localparam logic [2:0] RD_RESP = 3'd5;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] LAT_LAST    = 2'(RD_LATENCY - 1);

   logic [2:0]              state;
   logic                    live;
   logic                    aw_full;
   logic                    w_full;
   logic [31:0]             aw_addr;
   logic [DATA_WIDTH-1:0]   w_data;
   logic [DATA_WIDTH/8-1:0] w_strb;
   logic                    rd_prio;
   logic                    rd_ok;
   logic [1:0]              lat_cnt;
   logic                    wr_pend;
   logic                    rd_pend;
   logic                    grant_wr;
   logic                    grant_rd;
   logic                    wr_legal;
   logic                    rd_legal;

   assign s_axil_awready = live & ~aw_full;
   assign s_axil_wready  = live & ~w_full;
   assign s_axil_bvalid  = (state == WR_RESP);
   assign s_axil_rvalid  = (state == RD_RESP);
   assign s_axil_arready = grant_rd;

   assign wr_pend  = aw_full & w_full;
   assign rd_pend  = s_axil_arvalid;
   assign wr_legal = (aw_addr[2:0] == 3'd0) && (&w_strb) && (aw_addr[31:REG_ADDR_WIDTH] == '0);
   assign rd_legal = (s_axil_araddr[2:0] == 3'd0) && (s_axil_araddr[31:REG_ADDR_WIDTH] == '0);

   always_comb begin
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      if (state == IDLE && live) begin
         if (wr_pend && rd_pend) begin
            grant_rd = rd_prio;
            grant_wr = ~rd_prio;
         end else begin
            grant_wr = wr_pend;
            grant_rd = rd_pend;
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         live    <= 1'b0;
         aw_full <= 1'b0;
         w_full  <= 1'b0;
         aw_addr <= '0;
         w_data  <= '0;
         w_strb  <= '0;
      end else begin
         live <= 1'b1;
         if (state == WR_EXEC) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
         end else begin
            if (s_axil_awvalid && s_axil_awready) begin
               aw_full <= 1'b1;
               aw_addr <= s_axil_awaddr;
            end
            if (s_axil_wvalid && s_axil_wready) begin
               w_full <= 1'b1;
               w_data <= s_axil_wdata;
               w_strb <= s_axil_wstrb;
            end
         end
      end
   end

   // Priority flips only on contested grants, so single-sided traffic does not disturb alternation.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state        <= IDLE;
         rd_prio      <= 1'b0;
         rd_ok        <= 1'b0;
         lat_cnt      <= '0;
         o_reg_wen    <= 1'b0;
         o_reg_ren    <= 1'b0;
         o_reg_waddr  <= '0;
         o_reg_wdata  <= '0;
         o_reg_raddr  <= '0;
         s_axil_bresp <= RESP_OKAY;
         s_axil_rresp <= RESP_OKAY;
         s_axil_rdata <= '0;
      end else begin
         o_reg_wen <= 1'b0;
         o_reg_ren <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_wr) begin
                  state        <= WR_EXEC;
                  o_reg_wen    <= wr_legal;
                  s_axil_bresp <= wr_legal ? RESP_OKAY : RESP_SLVERR;
                  if (wr_legal) begin
                     o_reg_waddr <= aw_addr[REG_ADDR_WIDTH-1:0];
                     o_reg_wdata <= w_data;
                  end
                  if (rd_pend) rd_prio <= 1'b1;
               end else if (grant_rd) begin
                  state        <= RD_EXEC;
                  o_reg_ren    <= rd_legal;
                  rd_ok        <= rd_legal;
                  s_axil_rresp <= rd_legal ? RESP_OKAY : RESP_SLVERR;
                  s_axil_rdata <= '0;
                  if (rd_legal) o_reg_raddr <= s_axil_araddr[REG_ADDR_WIDTH-1:0];
                  if (wr_pend) rd_prio <= 1'b0;
               end
            end
            WR_EXEC: state <= WR_RESP;
            WR_RESP: if (s_axil_bready) state <= IDLE;
            RD_EXEC: begin
               state   <= RD_WAIT;
               lat_cnt <= '0;
            end
            RD_WAIT: begin
               if (lat_cnt == LAT_LAST) begin
                  if (rd_ok) s_axil_rdata <= i_reg_rdata;
                  state <= RD_RESP;
               end else begin
                  lat_cnt <= lat_cnt + 2'd1;
               end
            end
            RD_RESP: if (s_axil_rready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tlk2711_axil_reg_bridge.sv
// Directed bench: instance 0 uses RD_LATENCY=1, instance 1 uses RD_LATENCY=3.
module tb_tlk2711_axil_reg_bridge;

   logic        clk;
   logic        arst_n [2];
   logic [31:0] awaddr [2];
   logic        awvalid[2];
   logic        awready[2];
   logic [63:0] wdata  [2];
   logic [7:0]  wstrb  [2];
   logic        wvalid [2];
   logic        wready [2];
   logic [1:0]  bresp  [2];
   logic        bvalid [2];
   logic        bready [2];
   logic [31:0] araddr [2];
   logic        arvalid[2];
   logic        arready[2];
   logic [63:0] rdata  [2];
   logic [1:0]  rresp  [2];
   logic        rvalid [2];
   logic        rready [2];
   logic        wen    [2];
   logic [15:0] waddr  [2];
   logic [63:0] wdat   [2];
   logic        ren    [2];
   logic [15:0] raddr  [2];
   logic [63:0] reg_rdata[2];

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   int lat[2]      = '{1, 3};
   int wen_cnt[2]  = '{0, 0};
   int ren_cnt[2]  = '{0, 0};
   int wen_cyc[2]  = '{-100, -100};
   int ren_cyc[2]  = '{-100, -100};
   int simul[2]    = '{0, 0};
   logic [15:0] wen_addr[2];
   logic [63:0] wen_data[2];
   logic [15:0] ren_addr[2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      tlk2711_axil_reg_bridge #(
         .REG_ADDR_WIDTH(16), .DATA_WIDTH(64), .RD_LATENCY(g == 0 ? 1 : 3)
      ) u_dut (
         .clk(clk), .arst_n(arst_n[g]),
         .s_axil_awaddr(awaddr[g]), .s_axil_awvalid(awvalid[g]), .s_axil_awready(awready[g]),
         .s_axil_wdata(wdata[g]), .s_axil_wstrb(wstrb[g]), .s_axil_wvalid(wvalid[g]), .s_axil_wready(wready[g]),
         .s_axil_bresp(bresp[g]), .s_axil_bvalid(bvalid[g]), .s_axil_bready(bready[g]),
         .s_axil_araddr(araddr[g]), .s_axil_arvalid(arvalid[g]), .s_axil_arready(arready[g]),
         .s_axil_rdata(rdata[g]), .s_axil_rresp(rresp[g]), .s_axil_rvalid(rvalid[g]), .s_axil_rready(rready[g]),
         .o_reg_wen(wen[g]), .o_reg_waddr(waddr[g]), .o_reg_wdata(wdat[g]),
         .o_reg_ren(ren[g]), .o_reg_raddr(raddr[g]), .i_reg_rdata(reg_rdata[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] reg_model(input logic [15:0] a);
      return (a == 16'h0010) ? 64'hDEADBEEF_00000001 : {48'hC0DE_0000_0000, a};
   endfunction

   // Register file answers only in the cycle RD_LATENCY after the strobe; any other cycle returns junk.
   always @(posedge clk) begin
      #1;
      for (int k = 0; k < 2; k++)
         reg_rdata[k] = (cyc == ren_cyc[k] + lat[k]) ? reg_model(ren_addr[k]) : 64'hBADD_BADD_BADD_BADD;
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (wen[k]) begin
            wen_cnt[k]++; wen_cyc[k] = cyc; wen_addr[k] = waddr[k]; wen_data[k] = wdat[k];
         end
         if (ren[k]) begin
            ren_cnt[k]++; ren_cyc[k] = cyc; ren_addr[k] = raddr[k];
         end
         if (wen[k] && ren[k]) simul[k]++;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic out_any(input int k);
      return awready[k] | wready[k] | arready[k] | bvalid[k] | (|bresp[k]) | rvalid[k] | (|rresp[k]) |
             (|rdata[k]) | wen[k] | (|waddr[k]) | (|wdat[k]) | ren[k] | (|raddr[k]);
   endfunction

   task automatic axi_write(input int k, input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                            input int w_lead, output int hs, output logic [1:0] resp, output int bc);
      int t; bit aw_p, w_p, b_p;
      hs = -1; bc = -1; resp = 2'b11; aw_p = 1; w_p = 1; b_p = 1; t = 0;
      awaddr[k] = a; wdata[k] = d; wstrb[k] = s;
      while ((aw_p || w_p) && t < 50) begin
         awvalid[k] = aw_p && (t >= w_lead);
         wvalid[k]  = w_p;
         @(negedge clk);
         if (awvalid[k] && awready[k]) begin aw_p = 0; hs = cyc; end
         if (wvalid[k] && wready[k]) begin w_p = 0; hs = cyc; end
         @(posedge clk); #1; t++;
      end
      awvalid[k] = 0; wvalid[k] = 0;
      if (aw_p || w_p) check("aw_w_timeout", 64'd1, 64'd0);
      bready[k] = 1; t = 0;
      while (b_p && t < 50) begin
         @(negedge clk);
         if (bvalid[k]) begin b_p = 0; bc = cyc; resp = bresp[k]; end
         @(posedge clk); #1; t++;
      end
      bready[k] = 0;
      if (b_p) check("b_timeout", 64'd1, 64'd0);
   endtask

   task automatic axi_read(input int k, input logic [31:0] a, output int hs, output logic [63:0] d,
                           output logic [1:0] resp, output int rc);
      int t; bit p;
      hs = -1; rc = -1; d = '0; resp = 2'b11; p = 1; t = 0;
      araddr[k] = a; arvalid[k] = 1;
      while (p && t < 50) begin
         @(negedge clk);
         if (arready[k]) begin p = 0; hs = cyc; end
         @(posedge clk); #1; t++;
      end
      arvalid[k] = 0;
      if (p) check("ar_timeout", 64'd1, 64'd0);
      rready[k] = 1; p = 1; t = 0;
      while (p && t < 50) begin
         @(negedge clk);
         if (rvalid[k]) begin p = 0; rc = cyc; d = rdata[k]; resp = rresp[k]; end
         @(posedge clk); #1; t++;
      end
      rready[k] = 0;
      if (p) check("r_timeout", 64'd1, 64'd0);
   endtask

   // AW+W presented at t0, AR from t0+1: both pending in IDLE at t0+1.
   task automatic run_pair(input int k, output int t0);
      int t; bit aw_p, w_p, ar_p, b_p, r_p;
      aw_p = 1; w_p = 1; ar_p = 1; b_p = 1; r_p = 1; t = 0; t0 = cyc;
      awaddr[k] = 32'h20; wdata[k] = 64'h0102_0304_0506_0708; wstrb[k] = 8'hFF; araddr[k] = 32'h10;
      bready[k] = 1; rready[k] = 1;
      while ((aw_p || w_p || ar_p || b_p || r_p) && t < 40) begin
         awvalid[k] = aw_p; wvalid[k] = w_p; arvalid[k] = ar_p && (t >= 1);
         @(negedge clk);
         if (awvalid[k] && awready[k]) aw_p = 0;
         if (wvalid[k] && wready[k]) w_p = 0;
         if (arvalid[k] && arready[k]) ar_p = 0;
         if (bvalid[k]) b_p = 0;
         if (rvalid[k]) r_p = 0;
         @(posedge clk); #1; t++;
      end
      awvalid[k] = 0; wvalid[k] = 0; arvalid[k] = 0; bready[k] = 0; rready[k] = 0;
      if (aw_p || w_p || ar_p || b_p || r_p) check("pair_timeout", 64'd1, 64'd0);
   endtask

   typedef struct {
      bit          is_wr;
      int          k;
      logic [31:0] addr;
      logic [63:0] data;
      logic [7:0]  strb;
      int          w_lead;
      bit          exp_strobe;
      logic [1:0]  exp_resp;
      logic [63:0] exp_rdata;
   } vec_t;

   localparam int NV = 10;
   vec_t vec[NV];

   initial begin
      int hs, bc, rc, t0, wc0, rc0, t;
      logic [1:0]  resp;
      logic [63:0] d;
      bit seen;
      vec_t v;

      vec[0] = '{1, 0, 32'h0000_0008, 64'h1122334455667788, 8'hFF, 0, 1, 2'b00, 64'h0};
      vec[1] = '{1, 0, 32'h0000_0100, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 5, 0, 2'b10, 64'h0};
      vec[2] = '{0, 0, 32'h0000_0010, 64'h0, 8'h00, 0, 1, 2'b00, 64'hDEADBEEF_00000001};
      vec[3] = '{0, 1, 32'h0000_0010, 64'h0, 8'h00, 0, 1, 2'b00, 64'hDEADBEEF_00000001};
      vec[4] = '{0, 0, 32'h0000_0004, 64'h0, 8'h00, 0, 0, 2'b10, 64'h0};
      vec[5] = '{1, 0, 32'h0001_0000, 64'h5555_6666_7777_8888, 8'hFF, 0, 0, 2'b10, 64'h0};
      vec[6] = '{0, 0, 32'h0000_0018, 64'h0, 8'h00, 0, 1, 2'b00, 64'hC0DE_0000_0000_0018};
      vec[7] = '{1, 1, 32'h0000_00F0, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 2, 1, 2'b00, 64'h0};
      vec[8] = '{0, 1, 32'h0002_0008, 64'h0, 8'h00, 0, 0, 2'b10, 64'h0};
      vec[9] = '{1, 0, 32'h0000_0006, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0, 2'b10, 64'h0};

      for (int k = 0; k < 2; k++) begin
         arst_n[k] = 0; awaddr[k] = '0; awvalid[k] = 0; wdata[k] = '0; wstrb[k] = '0; wvalid[k] = 0;
         bready[k] = 0; araddr[k] = '0; arvalid[k] = 0; rready[k] = 0;
      end
      repeat (3) @(negedge clk);
      check("rst_outs_0", 64'(out_any(0)), 64'd0);
      check("rst_outs_1", 64'(out_any(1)), 64'd0);
      arst_n[0] = 1; arst_n[1] = 1;
      @(posedge clk); #1;
      check("rst_awready", 64'(awready[0]), 64'd1);
      check("rst_wready", 64'(wready[1]), 64'd1);

      run_pair(0, t0);
      check("arb1_wen_cyc", 64'(wen_cyc[0] - t0), 64'd2);
      check("arb1_ren_cyc", 64'(ren_cyc[0] - t0), 64'd5);
      run_pair(0, t0);
      check("arb2_ren_cyc", 64'(ren_cyc[0] - t0), 64'd2);
      check("arb2_wen_cyc", 64'(wen_cyc[0] - t0), 64'd6);

      for (int i = 0; i < NV; i++) begin
         v = vec[i];
         wc0 = wen_cnt[v.k]; rc0 = ren_cnt[v.k];
         if (v.is_wr) begin
            axi_write(v.k, v.addr, v.data, v.strb, v.w_lead, hs, resp, bc);
            check($sformatf("v%0d_bresp", i), 64'(resp), 64'(v.exp_resp));
            check($sformatf("v%0d_wen_count", i), 64'(wen_cnt[v.k] - wc0), 64'(v.exp_strobe));
            check($sformatf("v%0d_bvalid_lat", i), 64'(bc - hs), 64'd3);
            if (v.exp_strobe) begin
               check($sformatf("v%0d_wen_lat", i), 64'(wen_cyc[v.k] - hs), 64'd2);
               check($sformatf("v%0d_waddr", i), 64'(wen_addr[v.k]), 64'(v.addr[15:0]));
               check($sformatf("v%0d_wdata", i), wen_data[v.k], v.data);
            end
         end else begin
            axi_read(v.k, v.addr, hs, d, resp, rc);
            check($sformatf("v%0d_rresp", i), 64'(resp), 64'(v.exp_resp));
            check($sformatf("v%0d_rdata", i), d, v.exp_rdata);
            check($sformatf("v%0d_ren_count", i), 64'(ren_cnt[v.k] - rc0), 64'(v.exp_strobe));
            check($sformatf("v%0d_rvalid_lat", i), 64'(rc - hs), 64'(2 + lat[v.k]));
            if (v.exp_strobe) begin
               check($sformatf("v%0d_ren_lat", i), 64'(ren_cyc[v.k] - hs), 64'd1);
               check($sformatf("v%0d_raddr", i), 64'(ren_addr[v.k]), 64'(v.addr[15:0]));
            end
         end
      end

      // Back-pressure: bready held low while a second write queues in the holders.
      wc0 = wen_cnt[0];
      bready[0] = 0; awaddr[0] = 32'h30; wdata[0] = 64'h1111_2222_3333_4444; wstrb[0] = 8'hFF;
      awvalid[0] = 1; wvalid[0] = 1;
      @(negedge clk);
      check("bp_first_hs", 64'(awready[0] & wready[0]), 64'd1);
      @(posedge clk); #1;
      awaddr[0] = 32'h38; wdata[0] = 64'h9999_8888_7777_6666;
      t = 0;
      while ((awvalid[0] || wvalid[0]) && t < 10) begin
         @(negedge clk);
         seen = awvalid[0] && awready[0];
         if (wvalid[0] && wready[0]) begin @(posedge clk); #1; wvalid[0] = 0; end
         else begin @(posedge clk); #1; end
         if (seen) awvalid[0] = 0;
         t++;
      end
      check("bp_second_hs_done", 64'(awvalid[0] | wvalid[0]), 64'd0);
      awvalid[0] = 0; wvalid[0] = 0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("bp_wen_single", 64'(wen_cnt[0] - wc0), 64'd1);
      check("bp_awready_low", 64'(awready[0]), 64'd0);
      check("bp_wready_low", 64'(wready[0]), 64'd0);
      check("bp_bvalid_held", 64'(bvalid[0]), 64'd1);
      @(posedge clk); #1;
      bready[0] = 1;
      @(negedge clk);
      t0 = cyc;
      t = 0; seen = 0;
      while (!seen && t < 10) begin
         @(posedge clk); #1; @(negedge clk);
         seen = wen[0]; t++;
      end
      check("bp_second_wen_lat", 64'(cyc - t0), 64'd2);
      check("bp_second_waddr", 64'(waddr[0]), 64'h38);
      check("bp_second_wdata", wdat[0], 64'h9999_8888_7777_6666);
      @(posedge clk); #1; @(negedge clk);
      check("bp_second_bvalid", 64'(bvalid[0]), 64'd1);
      check("bp_second_bresp", 64'(bresp[0]), 64'd0);
      @(posedge clk); #1;
      bready[0] = 0;

      // Reset during RD_WAIT on the RD_LATENCY=3 instance.
      rc0 = ren_cnt[1];
      araddr[1] = 32'h10; arvalid[1] = 1; t = 0; seen = 0;
      while (!seen && t < 10) begin
         @(negedge clk); seen = arready[1];
         @(posedge clk); #1; t++;
      end
      check("mid_ar_hs", 64'(seen), 64'd1);
      arvalid[1] = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      arst_n[1] = 0;
      #1;
      check("mid_rst_outs", 64'(out_any(1)), 64'd0);
      @(negedge clk);
      @(negedge clk);
      check("mid_rst_outs_held", 64'(out_any(1)), 64'd0);
      arst_n[1] = 1;
      @(posedge clk); #1;
      check("mid_rel_awready", 64'(awready[1]), 64'd1);
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         seen = seen | rvalid[1] | bvalid[1] | ren[1] | wen[1];
      end
      check("mid_no_activity", 64'(seen), 64'd0);
      check("mid_ren_single", 64'(ren_cnt[1] - rc0), 64'd1);
      @(posedge clk); #1;
      axi_read(1, 32'h10, hs, d, resp, rc);
      check("mid_fresh_rdata", d, 64'hDEADBEEF_00000001);
      check("mid_fresh_rresp", 64'(resp), 64'd0);
      check("mid_fresh_rvalid_lat", 64'(rc - hs), 64'd5);

      check("no_simul_strobe_0", 64'(simul[0]), 64'd0);
      check("no_simul_strobe_1", 64'(simul[1]), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
